// File: rtl/datapath_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datapath_pkg: shared datapath widths, writeback entry type, helpers  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package datapath_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int REG_SELECT_WIDTH = 5;

    typedef logic [DATA_WIDTH-1:0]       data_t;
    typedef logic [REG_SELECT_WIDTH-1:0] reg_sel_t;

    localparam reg_sel_t REG_ZERO = '0;

    typedef struct packed {
        reg_sel_t select;
        data_t    data;
    } wb_entry_t;

    localparam int WB_ENTRY_WIDTH = $bits(wb_entry_t);

    function automatic logic is_zero_reg(input reg_sel_t sel);
        return (sel == REG_ZERO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | writeback_stage_if: execute-result, register-write and read bundle   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface writeback_stage_if;
    import datapath_pkg::*;

    logic     S2_ResultValid;
    logic     S2_ResultReady;
    data_t    S2_ResultData;
    reg_sel_t S2_ResultSelect;
    logic     S2_ResultWriteEnable;

    logic     S3_WriteGrant;
    data_t    S3_WriteData;
    reg_sel_t S3_WriteSelect;
    logic     S3_WriteEnable;

    reg_sel_t S1_ReadSelect1;
    reg_sel_t S1_ReadSelect2;
    data_t    RF_ReadData1;
    data_t    RF_ReadData2;
    data_t    S1_ReadData1;
    data_t    S1_ReadData2;
    logic     S1_Hazard;

    modport master (
        output S2_ResultValid, S2_ResultData, S2_ResultSelect, S2_ResultWriteEnable,
        output S3_WriteGrant,
        output S1_ReadSelect1, S1_ReadSelect2, RF_ReadData1, RF_ReadData2,
        input  S2_ResultReady,
        input  S3_WriteData, S3_WriteSelect, S3_WriteEnable,
        input  S1_ReadData1, S1_ReadData2, S1_Hazard
    );

    modport slave (
        input  S2_ResultValid, S2_ResultData, S2_ResultSelect, S2_ResultWriteEnable,
        input  S3_WriteGrant,
        input  S1_ReadSelect1, S1_ReadSelect2, RF_ReadData1, RF_ReadData2,
        output S2_ResultReady,
        output S3_WriteData, S3_WriteSelect, S3_WriteEnable,
        output S1_ReadData1, S1_ReadData2, S1_Hazard
    );

endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_fifo: FIFO_DEPTH-entry queue of writeback entries; exposes all    |
// | entries oldest-first with valid bits for bypass matching. Rev 1.0    |
// +----------------------------------------------------------------------+
module wb_fifo
    import datapath_pkg::*;
#(
    parameter  int FIFO_DEPTH = 2,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  wire logic                                 clk,
    input  wire logic                                 reset_n,
    input  wire logic                                 i_push,
    input  wire logic [WB_ENTRY_WIDTH-1:0]            i_push_entry,
    input  wire logic                                 i_pop,
    output wb_entry_t                                 o_head,
    output logic [CNT_W-1:0]                          o_count,
    output logic [FIFO_DEPTH*WB_ENTRY_WIDTH-1:0]      o_entries_flat,
    output logic [FIFO_DEPTH-1:0]                     o_entries_valid
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    wb_entry_t        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_pop  = i_pop  && (r_count != '0);
    assign w_do_push = i_push && (r_count != CNT_W'(FIFO_DEPTH));

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_tail] <= wb_entry_t'(i_push_entry);
                r_tail        <= r_tail + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

    generate
        for (genvar k = 0; k < FIFO_DEPTH; k++) begin : g_age_order
            assign o_entries_flat[k*WB_ENTRY_WIDTH +: WB_ENTRY_WIDTH] = r_mem[r_head + PTR_W'(k)];
            assign o_entries_valid[k] = (CNT_W'(k) < r_count);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | writeback_stage: buffers execute results and drives the register     |
// | file write port; owns the stage-1 read bypass. Optional macro        |
// | WB_FORWARD_EN enables the bypass mux (else hazard flag). Rev 1.0     |
// +----------------------------------------------------------------------+
module writeback_stage
    import datapath_pkg::*;
#(
    parameter  int FIFO_DEPTH = 2,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    writeback_stage_if.slave bus
);

    logic [CNT_W-1:0]                     w_count;
    wb_entry_t                            w_head;
    logic [FIFO_DEPTH*WB_ENTRY_WIDTH-1:0] w_entries_flat;
    logic [FIFO_DEPTH-1:0]                w_entries_valid;
    wb_entry_t                            w_entries [FIFO_DEPTH];

    logic      w_ready;
    logic      w_accept;
    logic      w_push;
    logic      w_pop;
    wb_entry_t w_push_entry;

    data_t     w_rd1;
    data_t     w_rd2;
    logic      w_hazard;

    // Ready depends only on the registered count; a same-edge pop never admits a push.
    assign w_ready  = (w_count < CNT_W'(FIFO_DEPTH));
    assign w_accept = bus.S2_ResultValid && w_ready;
    assign w_push   = w_accept && bus.S2_ResultWriteEnable && !is_zero_reg(bus.S2_ResultSelect);
    assign w_pop    = (w_count != '0) && bus.S3_WriteGrant;

    assign w_push_entry.select = bus.S2_ResultSelect;
    assign w_push_entry.data   = bus.S2_ResultData;

    wb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_push          (w_push),
        .i_push_entry    (w_push_entry),
        .i_pop           (w_pop),
        .o_head          (w_head),
        .o_count         (w_count),
        .o_entries_flat  (w_entries_flat),
        .o_entries_valid (w_entries_valid)
    );

    generate
        for (genvar k = 0; k < FIFO_DEPTH; k++) begin : g_unpack
            assign w_entries[k] = wb_entry_t'(w_entries_flat[k*WB_ENTRY_WIDTH +: WB_ENTRY_WIDTH]);
        end
    endgenerate

`ifdef WB_FORWARD_EN
    // Entries are oldest-first, so the last match in the scan is the youngest.
    always_comb begin
        w_rd1 = bus.RF_ReadData1;
        w_rd2 = bus.RF_ReadData2;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (w_entries_valid[k] && (w_entries[k].select == bus.S1_ReadSelect1)) begin
                w_rd1 = w_entries[k].data;
            end
            if (w_entries_valid[k] && (w_entries[k].select == bus.S1_ReadSelect2)) begin
                w_rd2 = w_entries[k].data;
            end
        end
        if (is_zero_reg(bus.S1_ReadSelect1)) begin
            w_rd1 = '0;
        end
        if (is_zero_reg(bus.S1_ReadSelect2)) begin
            w_rd2 = '0;
        end
    end

    assign w_hazard = 1'b0;
`else
    logic w_match1;
    logic w_match2;
    logic w_unused_data;

    always_comb begin
        w_match1      = 1'b0;
        w_match2      = 1'b0;
        w_unused_data = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (w_entries_valid[k] && (w_entries[k].select == bus.S1_ReadSelect1)) begin
                w_match1 = 1'b1;
            end
            if (w_entries_valid[k] && (w_entries[k].select == bus.S1_ReadSelect2)) begin
                w_match2 = 1'b1;
            end
            w_unused_data = w_unused_data ^ (^w_entries[k].data);
        end
    end

    assign w_rd1    = is_zero_reg(bus.S1_ReadSelect1) ? '0 : bus.RF_ReadData1;
    assign w_rd2    = is_zero_reg(bus.S1_ReadSelect2) ? '0 : bus.RF_ReadData2;
    assign w_hazard = (w_match1 && !is_zero_reg(bus.S1_ReadSelect1)) ||
                      (w_match2 && !is_zero_reg(bus.S1_ReadSelect2));
`endif

    assign bus.S2_ResultReady = w_ready;
    assign bus.S3_WriteEnable = (w_count != '0);
    assign bus.S3_WriteData   = w_head.data;
    assign bus.S3_WriteSelect = w_head.select;
    assign bus.S1_ReadData1   = w_rd1;
    assign bus.S1_ReadData2   = w_rd2;
    assign bus.S1_Hazard      = w_hazard;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_writeback_stage: vector table, directed corners and random run    |
// | against a queue-based reference model. Rev 1.0                       |
// +----------------------------------------------------------------------+
module tb_writeback_stage;
    import datapath_pkg::*;

    localparam int DEPTH = 2;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    writeback_stage_if u_if();

    writeback_stage #(
        .FIFO_DEPTH (DEPTH)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if.slave)
    );

    int n_total = 0;
    int n_pass  = 0;

    wb_entry_t model_q[$];

    typedef struct {
        bit       v;
        bit       we;
        reg_sel_t sel;
        data_t    d;
        bit       g;
        reg_sel_t r1;
        data_t    rf1;
        bit       e_ready;
        bit       e_we;
        reg_sel_t e_wsel;
        data_t    e_wdata;
        data_t    e_rd1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input bit v, input bit we, input reg_sel_t sel, input data_t d, input bit g,
                         input reg_sel_t r1, input data_t rf1, input reg_sel_t r2, input data_t rf2);
        u_if.S2_ResultValid       = v;
        u_if.S2_ResultWriteEnable = we;
        u_if.S2_ResultSelect      = sel;
        u_if.S2_ResultData        = d;
        u_if.S3_WriteGrant        = g;
        u_if.S1_ReadSelect1       = r1;
        u_if.RF_ReadData1         = rf1;
        u_if.S1_ReadSelect2       = r2;
        u_if.RF_ReadData2         = rf2;
    endtask

    function automatic data_t model_read(input reg_sel_t sel, input data_t rf);
        if (sel == 0) return '0;
        if (FWD) begin
            for (int i = model_q.size() - 1; i >= 0; i--)
                if (model_q[i].select == sel) return model_q[i].data;
        end
        return rf;
    endfunction

    function automatic bit model_hit(input reg_sel_t sel);
        if (sel == 0) return 1'b0;
        foreach (model_q[i]) if (model_q[i].select == sel) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_check(input string tag);
        chk({tag, ".ready"}, u_if.S2_ResultReady, model_q.size() < DEPTH);
        chk({tag, ".wen"},   u_if.S3_WriteEnable, model_q.size() != 0);
        if (model_q.size() != 0) begin
            chk({tag, ".wsel"},  u_if.S3_WriteSelect, model_q[0].select);
            chk({tag, ".wdata"}, u_if.S3_WriteData,   model_q[0].data);
        end
        chk({tag, ".rd1"}, u_if.S1_ReadData1, model_read(u_if.S1_ReadSelect1, u_if.RF_ReadData1));
        chk({tag, ".rd2"}, u_if.S1_ReadData2, model_read(u_if.S1_ReadSelect2, u_if.RF_ReadData2));
        chk({tag, ".hazard"}, u_if.S1_Hazard,
            !FWD && (model_hit(u_if.S1_ReadSelect1) || model_hit(u_if.S1_ReadSelect2)));
    endtask

    task automatic model_edge();
        bit acc, pop;
        acc = u_if.S2_ResultValid && (model_q.size() < DEPTH);
        pop = (model_q.size() != 0) && u_if.S3_WriteGrant;
        if (pop) void'(model_q.pop_front());
        if (acc && u_if.S2_ResultWriteEnable && (u_if.S2_ResultSelect != 0))
            model_q.push_back('{select: u_if.S2_ResultSelect, data: u_if.S2_ResultData});
    endtask

    task automatic cycle_begin(input string tag);
        @(negedge clk);
        model_check(tag);
    endtask

    task automatic cycle_end();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_cycle(input string tag);
        cycle_begin(tag);
        cycle_end();
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", u_if.S2_ResultReady, 1);
        chk("rst.wen",   u_if.S3_WriteEnable, 0);
        chk("rst.wdata", u_if.S3_WriteData,   0);
        chk("rst.wsel",  u_if.S3_WriteSelect, 0);
        chk("rst.hazard", u_if.S1_Hazard,     0);
        reset_n = 1'b1;

        // {v, we, sel, d, g, r1, rf1, e_ready, e_we, e_wsel, e_wdata, e_rd1}
        vecs.push_back('{1, 1, 3, 32'hDEADBEEF, 1, 2, 32'hA5A5A5A5, 1, 0, 0, 0,            32'hA5A5A5A5});
        vecs.push_back('{0, 0, 0, 32'h0,        1, 2, 32'hA5A5A5A5, 1, 1, 3, 32'hDEADBEEF, 32'hA5A5A5A5});
        vecs.push_back('{0, 0, 0, 32'h0,        1, 2, 32'hA5A5A5A5, 1, 0, 0, 0,            32'hA5A5A5A5});
        vecs.push_back('{1, 1, 4, 32'h44444444, 0, 2, 32'hA5A5A5A5, 1, 0, 0, 0,            32'hA5A5A5A5});
        vecs.push_back('{1, 1, 5, 32'h55555555, 0, 2, 32'hA5A5A5A5, 1, 1, 4, 32'h44444444, 32'hA5A5A5A5});
        vecs.push_back('{1, 1, 6, 32'h66666666, 0, 2, 32'hA5A5A5A5, 0, 1, 4, 32'h44444444, 32'hA5A5A5A5});
        vecs.push_back('{1, 1, 6, 32'h66666666, 1, 2, 32'hA5A5A5A5, 0, 1, 4, 32'h44444444, 32'hA5A5A5A5});
        vecs.push_back('{0, 0, 0, 32'h0,        1, 2, 32'hA5A5A5A5, 1, 1, 5, 32'h55555555, 32'hA5A5A5A5});
        vecs.push_back('{1, 1, 0, 32'hBADF000D, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0,            32'h0});
        vecs.push_back('{1, 0, 9, 32'h12345678, 0, 2, 32'hA5A5A5A5, 1, 0, 0, 0,            32'hA5A5A5A5});
        vecs.push_back('{0, 0, 0, 32'h0,        1, 0, 32'hFFFFFFFF, 1, 0, 0, 0,            32'h0});

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].we, vecs[i].sel, vecs[i].d, vecs[i].g,
                  vecs[i].r1, vecs[i].rf1, 0, 32'hFFFFFFFF);
            @(negedge clk);
            chk($sformatf("vec%0d.ready", i), u_if.S2_ResultReady, vecs[i].e_ready);
            chk($sformatf("vec%0d.wen", i),   u_if.S3_WriteEnable, vecs[i].e_we);
            if (vecs[i].e_we) begin
                chk($sformatf("vec%0d.wsel", i),  u_if.S3_WriteSelect, vecs[i].e_wsel);
                chk($sformatf("vec%0d.wdata", i), u_if.S3_WriteData,   vecs[i].e_wdata);
            end
            chk($sformatf("vec%0d.rd1", i), u_if.S1_ReadData1, vecs[i].e_rd1);
            model_check($sformatf("vec%0d", i));
            cycle_end();
        end

        // Duplicate selects: youngest wins for bypass, both written in order.
        drive(1, 1, 7, 32'h11111111, 0, 0, 0, 0, 0);
        run_cycle("dup.push1");
        drive(1, 1, 7, 32'h22222222, 0, 0, 0, 0, 0);
        run_cycle("dup.push2");
        drive(0, 0, 0, 0, 0, 7, 32'h0, 8, 32'h0000CAFE);
        cycle_begin("dup.read");
        chk("dup.rd1",    u_if.S1_ReadData1, FWD ? 32'h22222222 : 32'h0);
        chk("dup.hazard", u_if.S1_Hazard,    FWD ? 1'b0 : 1'b1);
        chk("dup.rd2",    u_if.S1_ReadData2, 32'h0000CAFE);
        cycle_end();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        cycle_begin("dup.wr1");
        chk("dup.wr1.data", u_if.S3_WriteData, 32'h11111111);
        cycle_end();
        cycle_begin("dup.wr2");
        chk("dup.wr2.data", u_if.S3_WriteData, 32'h22222222);
        cycle_end();
        run_cycle("dup.empty");

        // Reset pulse with a full buffer: entries vanish, nothing is written.
        drive(1, 1, 10, 32'hAAAA0010, 0, 0, 0, 0, 0);
        run_cycle("mrst.push1");
        drive(1, 1, 11, 32'hAAAA0011, 0, 0, 0, 0, 0);
        run_cycle("mrst.push2");
        drive(0, 0, 0, 0, 0, 10, 32'h0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst.wen",   u_if.S3_WriteEnable, 0);
        chk("mrst.ready", u_if.S2_ResultReady, 1);
        chk("mrst.wdata", u_if.S3_WriteData,   0);
        chk("mrst.hazard", u_if.S1_Hazard,     0);
        model_q.delete();
        #2 reset_n = 1'b1;
        cycle_end();
        drive(0, 0, 0, 0, 1, 10, 32'h0, 11, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle_begin("mrst.after");
            chk("mrst.after.wen", u_if.S3_WriteEnable, 0);
            cycle_end();
        end

        // Fill, then continuous push/pop across pointer wrap.
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, reg_sel_t'(i + 1), 32'hF0F00000 + i, 0, 0, 0, 0, 0);
            run_cycle("wrap.fill");
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, reg_sel_t'(i % 7 + 1), 32'hC0DE0000 + i, 1,
                  reg_sel_t'(i % 7 + 1), 32'h0, 0, 0);
            run_cycle($sformatf("wrap%0d", i));
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                  reg_sel_t'($urandom_range(0, 7)), data_t'($urandom), $urandom_range(0, 1) == 1,
                  reg_sel_t'($urandom_range(0, 7)), data_t'($urandom),
                  reg_sel_t'($urandom_range(0, 7)), data_t'($urandom));
            run_cycle($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
# writeback_stage

Stage-3 writer for the pipelined datapath's register file: accepts results from the execute stage over a valid/ready handshake, buffers them in a small FIFO, and drives the register file's write port (S3_WriteData/S3_WriteSelect/S3_WriteEnable) whenever the port is granted. It also owns the stage-1 read-side bypass, so reads of a register with a buffered, not-yet-written result return that result rather than the stale register file value. Register 0 is hard-wired zero: writes to it are dropped, and reads of it return 0.

## Interface
- DATA_WIDTH, 32, register width in bits
- REG_SELECT_WIDTH, 5, register select width (2^N registers)
- FIFO_DEPTH, 2, write-buffer entries (power of two, ≥2)

- clk  in  1  single clock, rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- S2_ResultValid  in  1  execute result present
- S2_ResultReady  out  1  stage can accept a result
- S2_ResultData  in  DATA_WIDTH  result value
- S2_ResultSelect  in  REG_SELECT_WIDTH  destination register
- S2_ResultWriteEnable  in  1  instruction writes a register
- S3_WriteGrant  in  1  register file write port available this cycle
- S3_WriteData  out  DATA_WIDTH  write data to register file
- S3_WriteSelect  out  REG_SELECT_WIDTH  write register select
- S3_WriteEnable  out  1  write request (head entry valid)
- S1_ReadSelect1, S1_ReadSelect2  in  REG_SELECT_WIDTH  stage-1 read selects (also fed to register file)
- RF_ReadData1, RF_ReadData2  in  DATA_WIDTH  raw register file read data
- S1_ReadData1, S1_ReadData2  out  DATA_WIDTH  bypassed read data to decode
- S1_Hazard  out  1  read select matches a buffered entry and bypass is compiled out

## Operation
- Accept on a clk edge where S2_ResultValid && S2_ResultReady.
- An accepted result with S2_ResultWriteEnable=0 or S2_ResultSelect=0 completes the handshake but is not enqueued.
- Otherwise {select, data} is pushed at the FIFO tail.
- S2_ResultReady = (count < FIFO_DEPTH), computed from registered count only. It has no combinational path from S3_WriteGrant.
- S3_* outputs show the head entry straight from FIFO storage. S3_WriteEnable = (count != 0).
- Pop on an edge where S3_WriteEnable && S3_WriteGrant. The register file captures the same write on that same edge.
- Simultaneous push and pop: count is unchanged, and the head advances while the tail is written.
- Bypass, per read port:
  - select 0 → 0.
  - Otherwise the youngest buffered entry with a matching select supplies the data.
  - Otherwise the port passes RF_ReadData through.
- The result being accepted in the current cycle is not a bypass source.

## Timing
- Reset values: count=0, S3_WriteEnable=0, S3_WriteData=0, S3_WriteSelect=0, S2_ResultReady=1, S1_Hazard=0. All FIFO storage is cleared.
- Latency: a result accepted at edge N is on S3_* during cycle N+1. With the grant held high, it is written at edge N+1.
- Bypass is combinational, select → S1_ReadData, in the same cycle.
- Full: S2_ResultReady=0. A pop at that edge does not allow a same-edge push; ready rises the cycle after the pop.
- Empty: S3_WriteEnable=0. The grant is ignored.
- Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation discards all buffered entries, and no write is issued for them.
- Duplicate selects in the FIFO are all written in order, so the final register value is the youngest entry.

## Configuration
- WB_FORWARD_EN defined: the bypass mux is present, and S1_Hazard is tied 0.
- WB_FORWARD_EN undefined:
  - S1_ReadData* = RF_ReadData*, except that select 0 still returns 0.
  - S1_Hazard=1 whenever either nonzero read select matches any buffered entry. The stall is the decode stage's responsibility.

## Structure
- Shared package datapath_pkg holds:
  - DATA_WIDTH and REG_SELECT_WIDTH constants.
  - The typedef wb_entry_t {select, data}.
  - The zero-register constant REG_ZERO = 0.
- Sub-module wb_fifo is a parameterised FIFO_DEPTH queue of wb_entry_t. It exposes head, count, and a flat vector of entries plus valid bits for the bypass match.
- The writeback_stage top holds the handshake, the drop logic, and the bypass/hazard logic.

## Test plan
- Reset, then accept {sel=3, data=DEADBEEF} with the grant held high → S3_WriteEnable=1, sel=3, data DEADBEEF in the next cycle. The FIFO is empty one cycle later.
- Grant held 0, accept sel=4 then sel=5 → ready falls to 0. With the grant raised, writes go out in order 4 then 5, and ready returns to 1 after the first pop.
- Result with sel=0 data BADF000D → handshake completes, S3_WriteEnable stays 0, and S1_ReadSelect1=0 reads 0 even with RF_ReadData1=FFFFFFFF.
- Grant 0, buffer sel=7:11111111 then sel=7:22222222, with RF_ReadData1=0 → S1_ReadData1=22222222 (youngest). Without WB_FORWARD_EN: S1_ReadData1=0 and S1_Hazard=1.
- Buffer 2 entries, then pulse reset_n low mid-cycle → S3_WriteEnable drops immediately, ready=1, and no write occurs after release.
- Full FIFO, then pop and push on consecutive edges for 8 cycles → the write order matches the accept order across pointer wrap.
